// File: rtl/snr_disp_pkg.sv
// Shared types and helpers for the SNR display sink: FSM states, segment
// constants and the active-low gfedcba digit encoder.
package snr_disp_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        CONVERT,
        UPDATE
    } state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         BCD_DIGITS = 3;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/snr_display_sink_bin2bcd.sv
// Sequential double-dabble: one shift/add-3 step per clock, BIN_WIDTH steps
// per conversion. start loads a new value; done flags the final step cycle.
module bin2bcd_seq
    import snr_disp_pkg::*;
#(
    parameter int BIN_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_WIDTH-1:0]      bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0]     bin_reg;
    logic [BCD_W-1:0]         bcd_reg;
    logic [BCD_W-1:0]         bcd_adj;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     busy_reg;
    logic [BCD_W+BIN_WIDTH-1:0] shift_val;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 :
                                    bcd_reg[4*gi +: 4];
    end

    assign shift_val = {bcd_adj, bin_reg} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            bin_reg  <= bin;
            bcd_reg  <= '0;
            cnt_reg  <= CNT_W'(BIN_WIDTH);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            bcd_reg <= shift_val[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
            bin_reg <= shift_val[BIN_WIDTH-1:0];
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy = busy_reg;
    assign done = busy_reg && (cnt_reg == CNT_W'(1));
    assign bcd  = bcd_reg;

endmodule

// File: rtl/snr_display_sink.sv
// SNR result sink: averages 2^AVG_SHIFT results, converts the average to
// three blanked 7-segment digits and keeps a decaying peak-hold value.
module snr_display_sink
    import snr_disp_pkg::*;
#(
    parameter int SNR_WIDTH        = 8,
    parameter int AVG_SHIFT        = 10,
    parameter int PEAK_HOLD_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SNR_WIDTH-1:0] snr_db,
    input  logic [SNR_WIDTH-1:0] snr_db_delta,
    input  logic                 snr_valid,
    output logic                 snr_ready,
    input  logic                 sel_delta,
    output logic [SNR_WIDTH-1:0] avg_snr,
    output logic [SNR_WIDTH-1:0] peak_snr,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1,
    output logic [6:0]           hex2,
    output logic                 disp_valid
);

    localparam int ACC_W   = SNR_WIDTH + AVG_SHIFT;
    localparam int BCD_W   = 4 * BCD_DIGITS;
    localparam int TIMER_W = $clog2(PEAK_HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HOLD_RELOAD = TIMER_W'(PEAK_HOLD_CYCLES);

    state_t                       state_reg, state_next;
    logic [ACC_W-1:0]             acc_reg;
    logic [ACC_W-1:0]             sum;
    logic [AVG_SHIFT-1:0]         count_reg;
    logic [SNR_WIDTH-1:0]         sample;
    logic [SNR_WIDTH-1:0]         pending_reg;
    logic [SNR_WIDTH-1:0]         avg_reg;
    logic [SNR_WIDTH-1:0]         peak_reg;
    logic [TIMER_W-1:0]           timer_reg;
    logic [BCD_DIGITS-1:0][6:0]   hex_reg;
    logic [BCD_DIGITS-1:0][6:0]   seg_next;
    logic [BCD_DIGITS-1:1]        blank_from;
    logic                         disp_valid_reg;
    logic                         transfer;
    logic                         window_end;
    logic                         conv_busy;
    logic                         conv_done;
    logic [BCD_W-1:0]             conv_bcd;

    assign snr_ready  = (state_reg == ACCUM) && !reset;
    assign transfer   = snr_valid && snr_ready;
    assign window_end = transfer && (&count_reg);
    assign sample     = sel_delta ? snr_db_delta : snr_db;
    assign sum        = acc_reg + ACC_W'(sample);

    bin2bcd_seq #(
        .BIN_WIDTH(SNR_WIDTH)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (window_end),
        .bin   (sum[ACC_W-1:AVG_SHIFT]),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // A digit is blanked only when it and every more significant digit are zero.
    for (genvar gi = 1; gi < BCD_DIGITS; gi++) begin : g_blank
        if (gi == BCD_DIGITS - 1) begin : g_top
            assign blank_from[gi] = (conv_bcd[4*gi +: 4] == 4'd0);
        end else begin : g_mid
            assign blank_from[gi] = (conv_bcd[4*gi +: 4] == 4'd0) && blank_from[gi+1];
        end
        assign seg_next[gi] = blank_from[gi] ? SEG_BLANK : seg7(conv_bcd[4*gi +: 4]);
    end
    assign seg_next[0] = seg7(conv_bcd[3:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leaving CONVERT if the converter is idle guards against a stuck FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (window_end) state_next = CONVERT;
            CONVERT: if (conv_done || !conv_busy) state_next = UPDATE;
            UPDATE:  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg        <= '0;
            count_reg      <= '0;
            pending_reg    <= '0;
            avg_reg        <= '0;
            peak_reg       <= '0;
            timer_reg      <= '0;
            hex_reg        <= {BCD_DIGITS{SEG_BLANK}};
            disp_valid_reg <= 1'b0;
        end else begin
            disp_valid_reg <= (state_reg == UPDATE);
            if (transfer) begin
                if (window_end) begin
                    acc_reg     <= '0;
                    count_reg   <= '0;
                    pending_reg <= sum[ACC_W-1:AVG_SHIFT];
                end else begin
                    acc_reg   <= sum;
                    count_reg <= count_reg + AVG_SHIFT'(1);
                end
            end
            if (state_reg == UPDATE) begin
                avg_reg <= pending_reg;
                hex_reg <= seg_next;
                // A larger average beats decay; an expired timer lets the peak fall.
                if ((pending_reg > peak_reg) || (timer_reg == '0)) begin
                    peak_reg  <= pending_reg;
                    timer_reg <= HOLD_RELOAD;
                end else begin
                    timer_reg <= timer_reg - TIMER_W'(1);
                end
            end else if (timer_reg != '0) begin
                timer_reg <= timer_reg - TIMER_W'(1);
            end
        end
    end

    assign avg_snr    = avg_reg;
    assign peak_snr   = peak_reg;
    assign hex0       = hex_reg[0];
    assign hex1       = hex_reg[1];
    assign hex2       = hex_reg[2];
    assign disp_valid = disp_valid_reg;

endmodule

// File: tb/tb_snr_display_sink.sv
// Scoreboard bench for snr_display_sink (AVG_SHIFT=2, PEAK_HOLD_CYCLES=100):
// stimulus pushes hand-computed window results, a monitor checks each disp_valid.
module tb_snr_display_sink;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] snr_db;
    logic [7:0] snr_db_delta;
    logic       snr_valid;
    logic       snr_ready;
    logic       sel_delta;
    logic [7:0] avg_snr;
    logic [7:0] peak_snr;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic       disp_valid;

    always #5 clk = ~clk;

    snr_display_sink #(
        .SNR_WIDTH        (8),
        .AVG_SHIFT        (2),
        .PEAK_HOLD_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .snr_db       (snr_db),
        .snr_db_delta (snr_db_delta),
        .snr_valid    (snr_valid),
        .snr_ready    (snr_ready),
        .sel_delta    (sel_delta),
        .avg_snr      (avg_snr),
        .peak_snr     (peak_snr),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .disp_valid   (disp_valid)
    );

    typedef struct {
        logic [7:0] avg;
        logic [7:0] peak;
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_xfer = 0;
    int   low_run = 0;
    int   disp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (disp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_disp_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    vectors++;
                    disp_count++;
                    if (avg_snr !== e.avg || peak_snr !== e.peak || hex2 !== e.h2 ||
                        hex1 !== e.h1 || hex0 !== e.h0 || cyc != e.at) begin
                        miscompares++;
                        $display("FAIL disp#%0d: got avg %0d peak %0d hex %h/%h/%h cyc %0d, expected avg %0d peak %0d hex %h/%h/%h cyc %0d",
                                 disp_count, avg_snr, peak_snr, hex2, hex1, hex0, cyc,
                                 e.avg, e.peak, e.h2, e.h1, e.h0, e.at);
                    end else begin
                        $display("disp#%0d avg %0d peak %0d hex %h/%h/%h cyc %0d ok",
                                 disp_count, avg_snr, peak_snr, hex2, hex1, hex0, cyc);
                    end
                end
            end
            if (reset) begin
                low_run = 0;
            end else if (!snr_ready) begin
                low_run++;
            end else begin
                if (low_run != 0) chk("ready_low_run", low_run, 9);
                low_run = 0;
            end
        end
    end

    task automatic send(input logic [7:0] db, input logic [7:0] dd, input logic sel);
        int waited;
        waited = 0;
        snr_db       = db;
        snr_db_delta = dd;
        sel_delta    = sel;
        snr_valid    = 1'b1;
        while (!snr_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!snr_ready) begin
            chk("transfer_timeout", 0, 1);
        end else begin
            @(negedge clk);
            last_xfer = cyc;
        end
    endtask

    // The unselected port carries the complement so a wrong mux choice shows.
    task automatic window(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3,
                          input logic sel, input logic [7:0] eavg, input logic [7:0] epeak,
                          input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        logic [7:0] s [4];
        exp_t e;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            send(sel ? ~s[i] : s[i], sel ? s[i] : ~s[i], sel);
        end
        e.avg = eavg; e.peak = epeak; e.h2 = e2; e.h1 = e1; e.h0 = e0;
        e.at  = last_xfer + 9;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        snr_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        snr_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", snr_ready, 1);
        chk("rst_hex2", hex2, 7'h7F);
        chk("rst_hex1", hex1, 7'h7F);
        chk("rst_hex0", hex0, 7'h7F);
        chk("rst_avg", avg_snr, 0);
        chk("rst_peak", peak_snr, 0);
        chk("rst_disp_valid", disp_valid, 0);
    endtask

    initial begin
        reset        = 1'b1;
        snr_valid    = 1'b0;
        sel_delta    = 1'b0;
        snr_db       = '0;
        snr_db_delta = '0;

        // 1: reset state
        repeat (3) begin
            @(negedge clk);
            chk("ready_in_reset", snr_ready, 0);
        end
        reset = 1'b0;
        #1;
        chk_reset_state();

        // 2: basic average 25
        window(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, 8'd25, 8'd25, 7'h7F, 7'h24, 7'h12);
        drain();

        // 3: three back-to-back windows with valid held high
        do_reset();
        window(8'd40,  8'd80,  8'd120, 8'd160, 1'b0, 8'd100, 8'd100, 7'h79, 7'h40, 7'h40);
        window(8'd104, 8'd108, 8'd112, 8'd116, 1'b0, 8'd110, 8'd110, 7'h79, 7'h79, 7'h40);
        window(8'd200, 8'd201, 8'd202, 8'd203, 1'b0, 8'd201, 8'd201, 7'h24, 7'h40, 7'h79);
        drain();

        // 4: delta source at full scale
        do_reset();
        window(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 8'd255, 8'd255, 7'h24, 7'h12, 7'h12);
        drain();

        // 5: peak hold and decay (13-cycle windows, timer 100)
        do_reset();
        window(8'd200, 8'd200, 8'd200, 8'd200, 1'b0, 8'd200, 8'd200, 7'h24, 7'h40, 7'h40);
        for (int k = 0; k < 7; k++) begin
            window(8'd50, 8'd50, 8'd50, 8'd50, 1'b0, 8'd50, 8'd200, 7'h7F, 7'h12, 7'h40);
        end
        window(8'd50, 8'd50, 8'd50, 8'd50, 1'b0, 8'd50, 8'd50, 7'h7F, 7'h12, 7'h40);
        window(8'd119, 8'd120, 8'd121, 8'd122, 1'b0, 8'd120, 8'd120, 7'h79, 7'h24, 7'h40);
        drain();

        // 6: reset three cycles into CONVERT aborts the window
        for (int i = 0; i < 4; i++) send(8'd99, 8'd0, 1'b0);
        snr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_state();
        window(8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 8'd7, 8'd7, 7'h7F, 7'h7F, 7'h78);
        drain();
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snr_display_sink.md
Name: snr_display_sink

Overview:
Consumer end of the SNR result stream. Accepts SNR results over a valid/ready handshake, selecting absolute or baseline-subtracted SNR per sample, and averages a power-of-two window of results. It converts each window average to decimal with a sequential double-dabble and drives three active-low 7-segment digits plus a decaying peak-hold value. Its ready output is the backpressure that throttles the audio stream upstream.

Parameters:
SNR_WIDTH, 8, width of incoming SNR values; legal range 4..9, result ≤ 511 fits 3 digits
AVG_SHIFT, 10, window length = 2^AVG_SHIFT accepted results
PEAK_HOLD_CYCLES, 50_000_000, clock cycles a captured peak is held before decay

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
snr_db  in  SNR_WIDTH  absolute SNR result
snr_db_delta  in  SNR_WIDTH  baseline-subtracted SNR result
snr_valid  in  1  result valid
snr_ready  out  1  sink ready; transfer occurs when snr_valid && snr_ready
sel_delta  in  1  0 = use snr_db, 1 = use snr_db_delta; sampled at each transfer
avg_snr  out  SNR_WIDTH  last completed window average
peak_snr  out  SNR_WIDTH  peak-hold of window averages
hex0  out  7  ones digit, active-low gfedcba
hex1  out  7  tens digit, active-low gfedcba
hex2  out  7  hundreds digit, active-low gfedcba
disp_valid  out  1  one-cycle pulse when avg/hex outputs update

Behaviour:
- Reset: state ACCUM; accumulator = 0; count = 0; avg_snr = 0; peak_snr = 0; hold timer = 0; hex0/1/2 = 7'h7F (blank); disp_valid = 0; snr_ready = 0 while reset is high.
- snr_ready = 1 only in ACCUM and reset low. It is decoded from state, with no combinational path from snr_valid.
- ACCUM state:
  - Each transfer adds the selected value, zero-extended, to a (SNR_WIDTH+AVG_SHIFT)-bit accumulator and increments count. The accumulator cannot overflow.
  - On the transfer where count == 2^AVG_SHIFT−1: latch (acc + sample) >> AVG_SHIFT (truncating) into the converter; clear acc and count; go to CONVERT.
- CONVERT state:
  - Runs SNR_WIDTH cycles of shift/add-3 double-dabble into a 12-bit BCD register, then goes to UPDATE.
  - snr_ready = 0 throughout.
- UPDATE state:
  - Lasts one cycle, snr_ready = 0, then returns to ACCUM.
  - The edge ending UPDATE registers avg_snr, hex0..2 and the peak logic, and asserts disp_valid for exactly the following cycle.
- Latency: final transfer at cycle T → outputs and disp_valid visible in cycle T+SNR_WIDTH+2. snr_ready is low for SNR_WIDTH+1 cycles per window.
- Digit encoding (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
- Leading-zero blanking:
  - hex2 = 7F if the hundreds digit is 0.
  - hex1 = 7F if the hundreds and tens digits are both 0.
  - hex0 is always shown.
- Peak hold, evaluated at UPDATE:
  - If avg > peak_snr: peak_snr <= avg and timer reloads PEAK_HOLD_CYCLES.
  - Otherwise the timer decrements every cycle, saturating at 0. When the timer is 0 at UPDATE, peak_snr <= avg and the timer reloads.
  - A new larger average always wins over decay in the same cycle.
- sel_delta changing mid-window mixes sources inside that window. This is permitted and the window is not restarted.
- snr_valid while snr_ready = 0: no transfer; the upstream holds its data.
- Reset mid-CONVERT/UPDATE: the conversion is aborted, no disp_valid is issued, and all state returns to reset values.

Decomposition:
- Package snr_disp_pkg:
  - state enum {ACCUM, CONVERT, UPDATE}
  - SEG_BLANK = 7'h7F
  - seg7 digit-encode function
  - BCD_DIGITS = 3
- Sub-module bin2bcd_seq:
  - Sequential double-dabble with start/busy/done.
  - SNR_WIDTH-cycle conversion, 12-bit BCD output.

Test Plan:
1. Reset high 3 cycles, then low → hex0..2 = 7F, avg = peak = 0, disp_valid = 0; snr_ready = 0 during reset, 1 in the first cycle after.
2. AVG_SHIFT=2, sel_delta=0, snr_db = 10, 20, 30, 40 → avg_snr = 25; hex2 = 7F, hex1 = 24, hex0 = 12; disp_valid pulses exactly 10 cycles after the 4th transfer.
3. AVG_SHIFT=2, snr_valid held high continuously for 3 windows → exactly 4 transfers per window; snr_ready low for 9 cycles between windows; no sample lost or double-counted (check sum per window).
4. sel_delta=1, snr_db_delta = 255 ×4, snr_db = 0 → avg = 255; hex2 = 24, hex1 = 12, hex0 = 12; peak_snr = 255.
5. PEAK_HOLD_CYCLES=100: window avg 200, then windows avg 50 → peak stays 200 until the first UPDATE after the timer hits 0, then becomes 50. A later avg 120 window raises the peak to 120 immediately.
6. Reset asserted 3 cycles into CONVERT → no disp_valid; all outputs at reset values; a following 4-sample window of value 7 yields hex0 = 78, hex1 = hex2 = 7F.
